// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane helper for the LSU: store strobes and lane replication,
// load lane extraction with sign/zero extension, unsupported-funct3 and misalign detect.
// Misalign detection is only built when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            we,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] load_data,
  output logic            unsupported,
  output logic            misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte lane follows addr[1:0]; halfword lane follows addr[1] only.
  assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
  assign half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Store strobes and replicated store data; loads never drive strobes.
  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    if (we) begin
      case (funct3)
        F3_B: begin
          wstrb     = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_H: begin
          wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end
        F3_W: begin
          wstrb     = 4'b1111;
          wdata_rep = wdata;
        end
        default: begin
          wstrb     = 4'b0000;
          wdata_rep = wdata;
        end
      endcase
    end else begin
      wstrb     = 4'b0000;
      wdata_rep = wdata;
    end
  end

  // Load lane extraction and extension; LW passes the word through unshifted.
  always_comb begin
    load_data = {XLEN{1'b0}};
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h000000, byte_s};
      F3_HU:   load_data = {16'h0000, half_s};
      default: load_data = {XLEN{1'b0}};
    endcase
  end

  // Encodings this unit does not implement complete immediately with an error.
  always_comb begin
    unsupported = 1'b0;
    if (we) begin
      unsupported = (funct3 >= 3'b011);
    end else begin
      case (funct3)
        3'b011, 3'b110, 3'b111: unsupported = 1'b1;
        default:                unsupported = 1'b0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = (addr_lo != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// Load/store unit: one word-aligned data-memory transaction in flight, aligned/extended
// load data or store completion returned to writeback as a one-cycle pulse.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned halfword/word ops fault without
// touching memory; handled inside lsu_align).
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [RD_W-1:0] req_rd,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  lsu_state_t state_r, next_state_s;

  logic [2:0]      funct3_r;
  logic [1:0]      addr_lo_r;
  logic [RD_W-1:0] rd_r;

  logic [2:0]      sel_funct3_s;
  logic [1:0]      sel_addr_s;
  logic            sel_we_s;
  logic [3:0]      wstrb_s;
  logic [XLEN-1:0] wdata_rep_s;
  logic [XLEN-1:0] load_data_s;
  logic            unsupported_s;
  logic            misalign_s;
  logic            trap_s;
  logic            accept_s;
  logic            load_mem_s;

  logic            wb_valid_s;
  logic [RD_W-1:0] wb_rd_s;
  logic [XLEN-1:0] wb_data_s;
  logic            wb_err_s;

  // In IDLE the helper decodes the incoming request; afterwards it serves the held op.
  assign sel_funct3_s = (state_r == IDLE) ? req_funct3     : funct3_r;
  assign sel_addr_s   = (state_r == IDLE) ? req_addr[1:0]  : addr_lo_r;
  assign sel_we_s     = (state_r == IDLE) ? req_we         : mem_we;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3      (sel_funct3_s),
    .we          (sel_we_s),
    .addr_lo     (sel_addr_s),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .wstrb       (wstrb_s),
    .wdata_rep   (wdata_rep_s),
    .load_data   (load_data_s),
    .unsupported (unsupported_s),
    .misalign    (misalign_s)
  );

  assign trap_s     = unsupported_s | misalign_s;
  assign accept_s   = (state_r == IDLE) && req_valid;
  assign load_mem_s = accept_s && !trap_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic; faulting requests bypass the memory phases.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) next_state_s = trap_s ? DONE : REQ;
        else           next_state_s = IDLE;
      end
      REQ: begin
        if (mem_ready) next_state_s = mem_we ? DONE : WAIT;
        else           next_state_s = REQ;
      end
      WAIT: begin
        if (mem_rvalid) next_state_s = DONE;
        else            next_state_s = WAIT;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Writeback values for the cycle in which the FSM will sit in DONE.
  always_comb begin
    wb_valid_s = 1'b0;
    wb_rd_s    = {RD_W{1'b0}};
    wb_data_s  = {XLEN{1'b0}};
    wb_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && trap_s) begin
          wb_valid_s = 1'b1;
          wb_err_s   = 1'b1;
          wb_data_s  = unsupported_s ? {XLEN{1'b0}} : req_addr;
        end else begin
          wb_valid_s = 1'b0;
        end
      end
      REQ: begin
        if (mem_ready && mem_we) wb_valid_s = 1'b1;
        else                     wb_valid_s = 1'b0;
      end
      WAIT: begin
        if (mem_rvalid) begin
          wb_valid_s = 1'b1;
          wb_rd_s    = rd_r;
          wb_data_s  = load_data_s;
        end else begin
          wb_valid_s = 1'b0;
        end
      end
      default: wb_valid_s = 1'b0;
    endcase
  end

  // Registered outputs and captured request fields; memory fields only change on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= {XLEN{1'b0}};
      mem_we    <= 1'b0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= {XLEN{1'b0}};
      funct3_r  <= 3'b000;
      addr_lo_r <= 2'b00;
      rd_r      <= {RD_W{1'b0}};
      wb_valid  <= 1'b0;
      wb_rd     <= {RD_W{1'b0}};
      wb_data   <= {XLEN{1'b0}};
      wb_err    <= 1'b0;
    end else begin
      req_ready <= (next_state_s == IDLE);
      mem_valid <= (next_state_s == REQ);
      if (load_mem_s) begin
        mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
        mem_we    <= req_we;
        mem_wstrb <= wstrb_s;
        mem_wdata <= wdata_rep_s;
        funct3_r  <= req_funct3;
        addr_lo_r <= req_addr[1:0];
        rd_r      <= req_rd;
      end
      wb_valid <= wb_valid_s;
      wb_rd    <= wb_rd_s;
      wb_data  <= wb_data_s;
      wb_err   <= wb_err_s;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: expected writeback results are pushed to a scoreboard when each
// op is driven and popped when wb_valid appears. Adapts to LSU_MISALIGN_TRAP_EN.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        mem;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model of the writeback result and memory-access decision.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] rdata, input logic [4:0] rd, input int stall);
    exp_t e;
    logic unsup, mis;
    logic [7:0] b;
    logic [15:0] h;
    unsup = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
`else
    mis = 1'b0;
`endif
    b = rdata[{addr[1:0], 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    e.mem = !unsup && !mis;
    e.rd = 5'd0; e.data = 32'd0; e.err = 1'b0;
    e.lat = e.mem ? ((we ? 2 : 3) + stall) : 1;
    if (unsup) begin
      e.err = 1'b1;
    end else if (mis) begin
      e.err = 1'b1; e.data = addr;
    end else if (!we) begin
      e.rd = rd;
      case (f3)
        3'd0: e.data = {{24{b[7]}}, b};
        3'd1: e.data = {{16{h[15]}}, h};
        3'd2: e.data = rdata;
        3'd4: e.data = {24'd0, b};
        default: e.data = {16'd0, h};
      endcase
    end
    return e;
  endfunction

  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int stall,
                        input logic [3:0] strb, input logic [31:0] wexp);
    exp_t e, got;
    int lat;
    e = model(we, f3, addr, rdata, rd, stall);
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd; mem_ready = (stall == 0);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    if (e.mem) begin
      for (int i = 0; i <= stall; i++) begin
        if (i == stall) mem_ready = 1'b1;
        check({tag, ".mem_valid"}, {31'd0, mem_valid}, 32'd1);
        check({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, we});
        if (we) begin
          check({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, strb});
          check({tag, ".mem_wdata"}, mem_wdata, wexp);
        end
        @(negedge clk);
        lat++;
      end
      mem_ready = 1'b0;
      check({tag, ".mem_valid_drop"}, {31'd0, mem_valid}, 32'd0);
      if (!we) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        lat++;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
      end
    end else begin
      check({tag, ".no_mem_valid"}, {31'd0, mem_valid}, 32'd0);
    end
    while (wb_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, got.rd});
      check({tag, ".wb_data"}, wb_data, got.data);
      check({tag, ".wb_err"}, {31'd0, wb_err}, {31'd0, got.err});
      check({tag, ".latency"}, lat, got.lat);
    end
    @(negedge clk);
    check({tag, ".wb_pulse_end"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; req_rd = 5'd0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst.mem_we", {31'd0, mem_we}, 32'd0);
    check("rst.mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.wb_err", {31'd0, wb_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("sw",  1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 32'd0, 0, 4'b1111, 32'hDEAD_BEEF);
    run_op("lb",  1'b0, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 32'h80FF_FF7F, 0, 4'b0000, 32'd0);
    run_op("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'd0, 5'd8, 32'h80FF_FF7F, 0, 4'b0000, 32'd0);
    run_op("sh",  1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd1, 32'd0, 3, 4'b1100, 32'hABCD_ABCD);
    run_op("sb",  1'b1, 3'b000, 32'h0000_0101, 32'h0000_00CD, 5'd2, 32'd0, 0, 4'b0010, 32'hCDCD_CDCD);
    run_op("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'd0, 5'd9, 32'hCAFE_F00D, 0, 4'b0000, 32'd0);
    run_op("lhu_mis", 1'b0, 3'b101, 32'h0000_0101, 32'd0, 5'd11, 32'h1234_5678, 1, 4'b0000, 32'd0);
    run_op("ld011", 1'b0, 3'b011, 32'h0000_0400, 32'd0, 5'd3, 32'd0, 0, 4'b0000, 32'd0);
    run_op("lh",  1'b0, 3'b001, 32'h0000_0102, 32'd0, 5'd10, 32'h8001_7FFF, 0, 4'b0000, 32'd0);
    run_op("st011", 1'b1, 3'b011, 32'h0000_0500, 32'h1111_2222, 5'd4, 32'd0, 0, 4'b0000, 32'd0);
    run_op("lw",  1'b0, 3'b010, 32'h0000_0200, 32'd0, 5'd31, 32'h0BAD_F00D, 2, 4'b0000, 32'd0);

    // Reset while a load waits for data; the late response must be ignored.
    check("rstwait.req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b101; req_addr = 32'h0000_0300; req_rd = 5'd12;
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstwait.mem_valid", {31'd0, mem_valid}, 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    check("rstwait.wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rstwait.req_ready2", {31'd0, req_ready}, 32'd1);
    check("rstwait.mem_valid2", {31'd0, mem_valid}, 32'd0);
    check("rstwait.wb_data", wb_data, 32'd0);
    check("rstwait.wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rstwait.mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    check("rstwait.wb_valid2", {31'd0, wb_valid}, 32'd0);
    check("rstwait.sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
